relu_maxpool_2x2: RTL
=====================

Name: relu_maxpool_2x2

Overview:
- Post-convolution stage directly downstream of the 3x3 convolution engine; consumes its 18-bit signed result stream (raster order, one sample per valid_in).
- Per sample: ReLU, then requantize to unsigned INT8 by arithmetic right shift with saturation.
- Then 2x2 stride-2 max pooling using a half-width row buffer; emits one INT8 pooled pixel per 2x2 window to the next layer's input.

Parameters:
- IN_COL, 126, conv output columns per row (input feature-map width)
- IN_ROW, 126, conv output rows per frame (input feature-map height)
- DIN_W, 18, input sample width (signed)
- DOUT_W, 8, output width (unsigned magnitude, MSB always 0)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  qualifies din this cycle
- din  input  DIN_W  signed conv result
- shift  input  5  requantize right-shift amount 0..17; static for a whole frame
- valid_out  output  1  one-cycle pulse per pooled pixel
- dout  output  DOUT_W  pooled pixel, range 0..127
- frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame

Behaviour:
- Reset (async assert, sync release): valid_out=0, dout=0, frame_done=0, col/row counters=0, pair-hold register=0, stage-1 valid=0. Row-buffer contents need not be cleared; they are never read before being written in the current frame.
- Stage 1 (registered, 1 cycle), taken when valid_in=1:
  - r = (din<0) ? 0 : din
  - q = r >>> shift, then clamp to 127
  - Internal width is DIN_W+1 so the rounding add cannot overflow.
  - Result q is registered with q_valid.
- Position counters advance on q_valid only.
  - col counts 0..IN_COL-1 and wraps to 0.
  - row increments on col wrap and counts 0..IN_ROW-1, then wraps to 0 (new frame).
- Pooling on q_valid, with c = col>>1:
  - Even col: pair-hold h <= q.
  - Odd col, even row: linebuf[c] <= max(h, q).
  - Odd col, odd row: dout <= max(linebuf[c], h, q); valid_out=1 next cycle.
- Odd IN_COL: last column is ignored for pooling (floor). Odd IN_ROW: last row is ignored. Counters still count these samples.
- Latency: valid_in of sample (2i+1, 2j+1) at cycle T gives valid_out high in cycle T+2. Fixed; independent of gaps.
- valid_in gaps of any length are allowed. All state holds; valid_out=0 in every cycle without a completing window.
- Back-to-back valid_in sustains 1 input/cycle; no backpressure, downstream must always accept.
- frame_done=1 with the valid_out for window (IN_ROW/2-1, IN_COL/2-1).
- Output count per frame is exactly floor(IN_ROW/2)*floor(IN_COL/2).
- All comparisons are unsigned on 7-bit values. Ties give the equal value.
- Reset asserted mid-frame: pipeline is flushed, no valid_out is produced for the partial window, and the next valid_in is treated as (0,0).
- Changing shift mid-frame is unsupported. The block applies the value sampled with each sample and does not flag it.

Optional Feature:
- Macro: RELU_POOL_ROUND_EN.
- Defined: round half up before the shift. When shift>0, add 1<<(shift-1) to r before shifting; then clamp.
- Undefined: plain truncating shift (floor), no adder; stage-1 logic is smaller.
- Latency and all other behaviour are identical in both builds.

Test Plan:
1. IN_COL=4, IN_ROW=4, shift=0. Stream rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16], continuous valid_in. Expect valid_out values 6, 8, 14, 16, one per window; frame_done only with the 16; each valid_out 2 cycles after its (odd,odd) input.
2. Same geometry, all din negative (e.g. -1000). Expect four outputs of 0.
3. shift=4, din=2000 everywhere:
   - Truncate build: 125.
   - With RELU_POOL_ROUND_EN: 2008>>4=125.
   - With din=24: truncate gives 1; round gives 2 (32>>4).
   - Saturation: din=131071, shift=0, gives 127.
4. IN_COL=5, IN_ROW=5 with a random valid_in duty cycle of 30%. Expect exactly 4 outputs that match a reference model, and no output for column 4 or row 4.
5. Two consecutive 4x4 frames with no gap. Expect 8 outputs, two frame_done pulses, and correct results in the second frame, proving wrap and row-buffer reuse.
6. rst_n asserted after 6 samples of a 4x4 frame, then a full fresh frame. Expect no output before the new frame, then exactly 4 correct outputs.

Source files
------------

// File: rtl/relu_maxpool_2x2.sv
// ReLU + INT8 requantize + 2x2/stride-2 max pool on a raster conv stream (RELU_POOL_ROUND_EN: round-half-up).
// Latency: valid_in of the (odd,odd) sample of a window to valid_out is 2 cycles, fixed.
// Backpressure: none; one sample per cycle accepted, downstream must always take valid_out.
`timescale 1ns/1ps
module relu_maxpool_2x2 #(
   parameter int IN_COL = 126,
   parameter int IN_ROW = 126,
   parameter int DIN_W  = 18,
   parameter int DOUT_W = 8
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic signed [DIN_W-1:0] din,
   input  logic [4:0]              shift,
   output logic                    valid_out,
   output logic [DOUT_W-1:0]       dout,
   output logic                    frame_done
);

   localparam int QW       = 7;
   localparam int HALF_COL = IN_COL / 2;
   localparam int HALF_ROW = IN_ROW / 2;
   localparam int CW       = (IN_COL > 1) ? $clog2(IN_COL) : 1;
   localparam int RW       = (IN_ROW > 1) ? $clog2(IN_ROW) : 1;
   localparam int LBW      = (HALF_COL > 1) ? $clog2(HALF_COL) : 1;

   localparam logic [CW-1:0] COL_MAX  = CW'(IN_COL - 1);
   localparam logic [RW-1:0] ROW_MAX  = RW'(IN_ROW - 1);
   localparam logic [CW-1:0] COL_LWIN = CW'(2 * HALF_COL - 1);
   localparam logic [RW-1:0] ROW_LWIN = RW'(2 * HALF_ROW - 1);

   function automatic logic [QW-1:0] max2(input logic [QW-1:0] a, input logic [QW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Stage 1: ReLU, optional rounding, shift, saturate to 0..127
   logic [DIN_W:0]  relu_v;
   logic [DIN_W:0]  sum_v;
   logic [DIN_W:0]  shr_v;
   logic [QW-1:0]   q_n;

   always_comb begin
      relu_v = din[DIN_W-1] ? '0 : {1'b0, din};
      sum_v  = relu_v;
`ifdef RELU_POOL_ROUND_EN
      if (shift != 5'd0)
         sum_v = relu_v + ((DIN_W+1)'(1) << (shift - 5'd1));
`endif
      shr_v = sum_v >> shift;
      q_n   = (shr_v > (DIN_W+1)'(127)) ? 7'd127 : shr_v[QW-1:0];
   end

   logic [QW-1:0] q_r;
   logic          q_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r   <= '0;
         q_vld <= 1'b0;
      end else begin
         q_vld <= valid_in;
         if (valid_in)
            q_r <= q_n;
      end
   end

   // Stage 2: position tracking and pooling
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [QW-1:0]  h;
   logic [QW-1:0]  linebuf [HALF_COL];
   logic [LBW-1:0] lb_idx;
   logic [QW-1:0]  lb_rd;
   logic           win_last;

   assign lb_idx   = LBW'(col >> 1);
   assign lb_rd    = linebuf[lb_idx];
   assign win_last = (col == COL_LWIN) && (row == ROW_LWIN);

   // Row buffer holds the even-row pair maxima; always written before read within a frame
   always_ff @(posedge clk) begin
      if (q_vld && col[0] && !row[0])
         linebuf[lb_idx] <= max2(h, q_r);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         h          <= '0;
         valid_out  <= 1'b0;
         dout       <= '0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (q_vld) begin
            if (col == COL_MAX) begin
               col <= '0;
               row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            if (!col[0]) begin
               h <= q_r;
            end else if (row[0]) begin
               dout       <= DOUT_W'(max2(lb_rd, max2(h, q_r)));
               valid_out  <= 1'b1;
               frame_done <= win_last;
            end
         end
      end
   end

endmodule
